ofs_plat_prim_stream_realign_words: RTL

// Streaming word realigner for PCIe-style payloads. Strips a per-packet

---
 rtl/ofs_plat_prim_stream_realign_words.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ofs_plat_prim_stream_realign_words.sv
// Streaming word realigner: drops a per-packet leading offset of S words and
// packs every output beat with the next NUM_WORDS words of the packet.

module ofs_plat_prim_rshift_words_comb #(
    parameter int DATA_WIDTH   = 1024,
    parameter int WORD_WIDTH   = 32,
    parameter int RESULT_WIDTH = DATA_WIDTH,
    parameter int NUM_WORDS    = DATA_WIDTH / WORD_WIDTH,
    parameter int RES_WORDS    = RESULT_WIDTH / WORD_WIDTH,
    parameter int SHIFT_W      = $clog2(NUM_WORDS)
) (
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [SHIFT_W-1:0]      shift,
    output logic [RESULT_WIDTH-1:0] result
);
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] words;
    logic [RES_WORDS-1:0][WORD_WIDTH-1:0] res_words;

    assign words  = data;
    assign result = res_words;

    for (genvar i = 0; i < RES_WORDS; i++) begin : g_word
        logic [WORD_WIDTH-1:0] sel;
        always_comb begin
            sel = '0;
            for (int j = 0; j < NUM_WORDS; j++) begin
                if (j == i + int'(shift)) sel = words[j];
            end
        end
        assign res_words[i] = sel;
    end
endmodule

module ofs_plat_prim_stream_realign_words #(
    parameter int DATA_WIDTH = 512,
    parameter int WORD_WIDTH = 32,
    localparam int N  = DATA_WIDTH / WORD_WIDTH,
    localparam int IW = $clog2(N),
    localparam int CW = $clog2(N) + 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [IW-1:0]         in_start_word,
    input  logic [CW-1:0]         in_eop_words,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [CW-1:0]         out_num_words
);
    localparam logic [CW-1:0] N_WORDS = CW'(N);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] h_data;
    logic                  h_eop;
    logic [CW-1:0]         h_words;
    logic [IW-1:0]         s;
    logic                  first_out;

    logic                  need_next;
    logic                  last_pair;
    logic                  eop_raw;
    logic [CW-1:0]         num_words;
    logic                  in_fire;
    logic                  out_fire;
    logic [N-1:0][WORD_WIDTH-1:0] shifted_words;
    logic [N-1:0][WORD_WIDTH-1:0] masked_words;
    logic [DATA_WIDTH-1:0] shifted;

    assign need_next = (state == HOLD) && !h_eop && (s != '0);

    // With S==0 or an EOP in H, the upper half is shifted in but always masked
    // off by num_words, so one shifter covers every case.
    ofs_plat_prim_rshift_words_comb #(
        .DATA_WIDTH   (2 * DATA_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH),
        .RESULT_WIDTH (DATA_WIDTH)
    ) u_shift (
        .data   ({in_data, h_data}),
        .shift  ({1'b0, s}),
        .result (shifted)
    );

    assign shifted_words = shifted;

    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        eop_raw   = 1'b0;
        last_pair = 1'b0;
        num_words = '0;
        if (state == IDLE) begin
            in_ready = !reset;
        end else if (need_next) begin
            out_valid = in_valid;
            in_ready  = out_ready;
            if (in_eop && (in_eop_words <= {1'b0, s})) begin
                eop_raw   = 1'b1;
                last_pair = 1'b1;
                num_words = N_WORDS - {1'b0, s} + in_eop_words;
            end else begin
                num_words = N_WORDS;
            end
        end else begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            eop_raw   = h_eop;
            num_words = (h_eop ? h_words : N_WORDS) - {1'b0, s};
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            masked_words[i] = (out_valid && (CW'(i) < num_words)) ? shifted_words[i] : '0;
        end
    end

    assign out_data      = masked_words;
    assign out_num_words = out_valid ? num_words : '0;
    assign out_sop       = out_valid && first_out;
    assign out_eop       = out_valid && eop_raw;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            h_data    <= '0;
            h_eop     <= 1'b0;
            h_words   <= '0;
            s         <= '0;
            first_out <= 1'b0;
        end else begin
            if (out_fire) first_out <= 1'b0;
            if (in_fire && in_sop) begin
                s         <= in_start_word;
                first_out <= 1'b1;
            end
            // Any accepted beat that is not the tail of a final pair becomes H.
            if (in_fire && !last_pair) begin
                h_data  <= in_data;
                h_eop   <= in_eop;
                h_words <= in_eop_words;
                state   <= HOLD;
            end else if (out_fire) begin
                state <= IDLE;
            end
        end
    end

    a_idle_sop: assert property (@(posedge clk) disable iff (reset)
        (in_fire && state == IDLE && !in_sop) |-> (s == '0));
    a_mid_sop: assert property (@(posedge clk) disable iff (reset)
        (in_fire && state == HOLD && !h_eop) |-> !in_sop);
    a_single_beat: assert property (@(posedge clk) disable iff (reset)
        (in_fire && in_sop && in_eop) |-> (in_eop_words > {1'b0, in_start_word}));
endmodule
